// File: rtl/clk_gate_ctl_if.sv
// Signal bundle between a gated unit's requester and its clock-gate enable controller.
// The controller takes the slave side; the requester / gated unit takes the master side.
interface clk_gate_ctl_if #(
    parameter int CNT_W = 16
);
    logic             req;
    logic             busy;
    logic             force_on;
    logic             gate_en;
    logic             ack;
    logic [1:0]       state;
    logic [CNT_W-1:0] off_count;

    modport master (
        output req,
        output busy,
        output force_on,
        input  gate_en,
        input  ack,
        input  state,
        input  off_count
    );

    modport slave (
        input  req,
        input  busy,
        input  force_on,
        output gate_en,
        output ack,
        output state,
        output off_count
    );
endinterface

// File: rtl/clk_gate_ctl.sv
// Enable controller for a phi1 clock gater: wakes the gated unit on demand and shuts it off
// after a programmable idle window, with a minimum off time against chatter.
module clk_gate_ctl #(
    parameter int IDLE_CYCLES = 16,
    parameter int MIN_OFF     = 2,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          reset,
    clk_gate_ctl_if.slave bus
);
    localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int TMR_W  = (MIN_OFF > 0) ? $clog2(MIN_OFF + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_SAT   = TMR_W'(MIN_OFF);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_WAKE  = 2'b01,
        ST_ON    = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    state_t            state_reg, state_next;
    logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
    logic [TMR_W-1:0]  off_tmr_reg, off_tmr_next;
    logic [CNT_W-1:0]  off_count_reg, off_count_next;
    logic              gate_en_reg;
    logic              ack_reg;

    logic wake;
    logic idle;
    logic tmr_ready;
    logic last_idle;

    assign wake      = bus.req | bus.force_on;
    assign idle      = ~(bus.req | bus.busy | bus.force_on);
    assign tmr_ready = (MIN_OFF == 0) || (off_tmr_reg >= TMR_SAT);
    assign last_idle = (idle_cnt_reg == IDLE_LAST);

    // Outputs are flopped from the next state so gate_en never passes through a
    // multi-bit state decode and cannot glitch on the WAKE->ON transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_OFF;
            idle_cnt_reg  <= '0;
            off_tmr_reg   <= '0;
            off_count_reg <= '0;
            gate_en_reg   <= 1'b0;
            ack_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idle_cnt_reg  <= idle_cnt_next;
            off_tmr_reg   <= off_tmr_next;
            off_count_reg <= off_count_next;
            gate_en_reg   <= (state_next != ST_OFF);
            ack_reg       <= (state_next == ST_ON);
        end
    end

    always_comb begin
        state_next     = state_reg;
        idle_cnt_next  = '0;
        off_tmr_next   = '0;
        off_count_next = off_count_reg;

        case (state_reg)
            ST_OFF: begin
                if (wake && tmr_ready) begin
                    state_next = ST_WAKE;
                end
                off_tmr_next = (off_tmr_reg == TMR_SAT) ? off_tmr_reg : off_tmr_reg + 1'b1;
            end
            ST_WAKE: begin
                state_next = ST_ON;
            end
            ST_ON: begin
                if (idle && last_idle) begin
                    state_next = ST_DRAIN;
                end else if (idle) begin
                    idle_cnt_next = idle_cnt_reg + 1'b1;
                end
            end
            default: begin
                // Final confirmation cycle: any activity cancels the shutdown.
                if (idle) begin
                    state_next = ST_OFF;
                    if (!(&off_count_reg)) begin
                        off_count_next = off_count_reg + 1'b1;
                    end
                end else begin
                    state_next = ST_ON;
                end
            end
        endcase
    end

    always_comb begin
        bus.gate_en   = gate_en_reg;
        bus.ack       = ack_reg;
        bus.state     = state_reg;
        bus.off_count = off_count_reg;
    end
endmodule
